yuv422_axis_serializer: RTL

- Downstream neighbour of the YUV444→YUV422 converter in the palette_lut path.
- Takes one YUV422 pixel pair per input beat (y0, u, y1, v plus frame/line flags) and emits one 16-bit pixel per output beat on an AXI4-Stream master, in YUYV or UVYY-swapped (UYVY) order, for the video output DMA/encoder.
- Provides valid/ready backpressure so the upstream converter can be stalled through its cen.

---
 rtl/yuv_stream_pkg.sv | 48 ++++
 rtl/yuv422_axis_serializer_if.sv | 23 ++
 rtl/yuv422_axis_serializer.sv | 111 +++++++++++
 3 files changed

// File: rtl/yuv_stream_pkg.sv
// Shared definitions for the YUV422 streaming stages.
//   PIX_W          : width of one luma/chroma component.
//   *_Y_LSB/_C_LSB : bit position of luma and chroma inside a 16-bit beat,
//                    for YUYV (Y in low byte) and UYVY (chroma in low byte).
//   yuv_pair_t     : one 4:2:2 pixel pair with frame/line flags.
//   ser_state_e    : serializer state (empty / showing pixel 0 / pixel 1).
//   pack_beat()    : places a Y and a chroma byte into a beat.
package yuv_stream_pkg;

  localparam int PIX_W  = 8;
  localparam int BEAT_W = 2 * PIX_W;

  localparam int YUYV_Y_LSB = 0;
  localparam int YUYV_C_LSB = PIX_W;
  localparam int UYVY_Y_LSB = PIX_W;
  localparam int UYVY_C_LSB = 0;

  typedef struct packed {
    logic [PIX_W-1:0] y0;
    logic [PIX_W-1:0] u;
    logic [PIX_W-1:0] y1;
    logic [PIX_W-1:0] v;
    logic             sof;
    logic             eol;
  } yuv_pair_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PIX0  = 2'd1,
    ST_PIX1  = 2'd2
  } ser_state_e;

  function automatic logic [BEAT_W-1:0] pack_beat(input logic [PIX_W-1:0] y,
                                                  input logic [PIX_W-1:0] c,
                                                  input bit uyvy);
    logic [BEAT_W-1:0] beat;
    beat = '0;
    if (uyvy) begin
      beat[UYVY_Y_LSB +: PIX_W] = y;
      beat[UYVY_C_LSB +: PIX_W] = c;
    end else begin
      beat[YUYV_Y_LSB +: PIX_W] = y;
      beat[YUYV_C_LSB +: PIX_W] = c;
    end
    return beat;
  endfunction

endpackage

// File: rtl/yuv422_axis_serializer_if.sv
// AXI4-Stream pixel bus carried out of the serializer.
//   tdata  : 16-bit pixel beat
//   tvalid : beat valid (source)
//   tready : sink can take the beat
//   tuser  : start of frame, first pixel only
//   tlast  : end of line, last pixel only
// Handshake: a beat transfers on a rising clk edge where tvalid && tready;
// once tvalid is high, the source holds tdata/tuser/tlast stable and keeps
// tvalid high until that transfer happens.
interface yuv422_axis_serializer_if;
  import yuv_stream_pkg::*;

  logic [BEAT_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast,
                  input  tready);
  modport slave  (input  tdata, input  tvalid, input  tuser, input  tlast,
                  output tready);
endinterface

// File: rtl/yuv422_axis_serializer.sv
// Serializes one YUV422 pixel pair per input beat into two 16-bit pixels on
// an AXI4-Stream master (YUYV or UYVY byte order).
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   s_valid / s_ready : input pair handshake (s_ready drives upstream cen)
//   s_y0,s_u,s_y1,s_v : pair components; s_sof / s_eol frame/line flags
//   m_axis            : AXI4-Stream master (tdata/tvalid/tready/tuser/tlast)
//   frame_cnt         : number of accepted s_sof pairs (wraps)
//   sof_err           : sticky, SOF seen while the previous line was open
//   dbg_state         : current serializer state
// Input handshake: a pair transfers on a rising clk edge where
// s_valid && s_ready; s_valid may drop without a transfer at no cost.
module yuv422_axis_serializer
  import yuv_stream_pkg::*;
#(
  parameter int UYVY   = 0,
  parameter int FCNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [PIX_W-1:0]         s_y0,
  input  logic [PIX_W-1:0]         s_u,
  input  logic [PIX_W-1:0]         s_y1,
  input  logic [PIX_W-1:0]         s_v,
  input  logic                     s_sof,
  input  logic                     s_eol,
  yuv422_axis_serializer_if.master m_axis,
  output logic [FCNT_W-1:0]        frame_cnt,
  output logic                     sof_err,
  output ser_state_e               dbg_state
);

  localparam bit SWAP = (UYVY != 0);

  ser_state_e state_q;
  yuv_pair_t  pair_q;
  logic       line_open_q;
  logic       in_fire;
  logic       pair_valid;
  logic       phase;

  logic [PIX_W-1:0] beat_y;
  logic [PIX_W-1:0] beat_c;
  logic             beat_user;
  logic             beat_last;

  assign pair_valid = (state_q != ST_EMPTY);
  assign phase      = (state_q == ST_PIX1);

  // Ready looks at tready combinationally so a new pair can load in the same
  // cycle pixel 1 leaves: 1 pixel/clk with no bubbles.
  assign s_ready = !pair_valid || (phase && m_axis.tready);
  assign in_fire = s_valid && s_ready;

  always_comb begin
    beat_y    = pair_q.y0;
    beat_c    = pair_q.u;
    beat_user = pair_q.sof;
    beat_last = 1'b0;
    if (phase) begin
      beat_y    = pair_q.y1;
      beat_c    = pair_q.v;
      beat_user = 1'b0;
      beat_last = pair_q.eol;
    end
  end

  // Outputs come only from registered state; gated to zero when empty.
  assign m_axis.tvalid = pair_valid;
  assign m_axis.tdata  = pair_valid ? pack_beat(beat_y, beat_c, SWAP) : '0;
  assign m_axis.tuser  = pair_valid && beat_user;
  assign m_axis.tlast  = pair_valid && beat_last;
  assign dbg_state     = state_q;

  // Pair register and phase FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      pair_q  <= '0;
    end else begin
      if (in_fire) begin
        pair_q <= '{y0: s_y0, u: s_u, y1: s_y1, v: s_v, sof: s_sof, eol: s_eol};
      end
      case (state_q)
        ST_EMPTY: if (in_fire)       state_q <= ST_PIX0;
        ST_PIX0:  if (m_axis.tready) state_q <= ST_PIX1;
        ST_PIX1:  if (m_axis.tready) state_q <= in_fire ? ST_PIX0 : ST_EMPTY;
        default:                     state_q <= ST_EMPTY;
      endcase
    end
  end

  // Frame counter and line-structure checking. line_open is high exactly
  // when the last accepted pair had eol=0, so it alone flags a missing EOL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      sof_err     <= 1'b0;
      line_open_q <= 1'b0;
    end else if (in_fire) begin
      line_open_q <= !s_eol;
      if (s_sof) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (line_open_q) sof_err <= 1'b1;
      end
    end
  end

endmodule
